// File: rtl/rr_buf_sched.sv
// rr_buf_sched
//   Round-robin scheduler sharing a DEPTH-entry byte buffer between NREQ
//   producers and draining it to one consumer over a valid/ready handshake.
//   Every buffered word carries the index of the requester that wrote it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears pointers and storage)
//   req        per-requester write request, bit i = requester i
//   wdata      requester i data in bits [i*DW +: DW]
//   gnt        one-hot combinational grant; the granted word is written at
//              the next rising edge
//   out_valid  buffer holds at least one word
//   out_ready  consumer accepts the head word this cycle
//   out_data   head word, read straight from registered storage
//   out_src    index of the requester that wrote the head word
//   count      current occupancy, 0..DEPTH
module rr_buf_sched #(
    parameter  int NREQ  = 4,
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int SW    = $clog2(NREQ),
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [SW-1:0]     out_src,
    output logic [CW-1:0]     count
);

    logic [DW-1:0] r_mem_data [DEPTH];
    logic [SW-1:0] r_mem_src  [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [SW-1:0] r_pp;
    logic [CW-1:0] r_count;

    logic          w_found;
    logic [SW-1:0] w_gnt_idx;
    logic          w_wr;
    logic          w_rd;
    logic          w_full;
    int            w_idx;

    assign w_full = (r_count == CW'(DEPTH));

    // Priority search starting at r_pp and wrapping past NREQ-1; picks the
    // first requesting index. Grant is suppressed when full or in reset.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = {SW{1'b0}};
        w_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_pp) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = SW'(w_idx);
            end else begin
                w_found   = w_found;
            end
        end
        if (w_found && rst && !w_full) begin
            w_wr = 1'b1;
            gnt  = NREQ'(1'b1) << w_gnt_idx;
        end else begin
            w_wr = 1'b0;
            gnt  = {NREQ{1'b0}};
        end
    end

    // A read only happens when there is something to read.
    assign w_rd      = (r_count != {CW{1'b0}}) && out_ready;
    assign out_valid = (r_count != {CW{1'b0}});
    assign out_data  = r_mem_data[r_rp];
    assign out_src   = r_mem_src[r_rp];
    assign count     = r_count;

    // Storage: write granted word with its source tag; cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= {DW{1'b0}};
                r_mem_src[i]  <= {SW{1'b0}};
            end
        end else if (w_wr) begin
            r_mem_data[r_wp] <= wdata[w_gnt_idx*DW +: DW];
            r_mem_src[r_wp]  <= w_gnt_idx;
        end else begin
            r_mem_data[r_wp] <= r_mem_data[r_wp];
        end
    end

    // Write pointer and priority pointer move only on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp <= {AW{1'b0}};
            r_pp <= {SW{1'b0}};
        end else if (w_wr) begin
            r_wp <= r_wp + AW'(1);
            if (w_gnt_idx == SW'(NREQ - 1)) begin
                r_pp <= {SW{1'b0}};
            end else begin
                r_pp <= w_gnt_idx + SW'(1);
            end
        end else begin
            r_wp <= r_wp;
            r_pp <= r_pp;
        end
    end

    // Read pointer advances on an accepted head word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rp <= {AW{1'b0}};
        end else if (w_rd) begin
            r_rp <= r_rp + AW'(1);
        end else begin
            r_rp <= r_rp;
        end
    end

    // Occupancy: simultaneous read and write cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= {CW{1'b0}};
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_buf_sched.sv
// Testbench for rr_buf_sched: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the buffer.
module tb_rr_buf_sched;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of {src, data} and the priority index.
    logic [9:0] mq[$];
    int         m_pp = 0;
    int         last_g = -1;

    rr_buf_sched #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wdata     (wdata),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_gidx();
        if (rst !== 1'b1 || mq.size() >= DEPTH) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_pp + k) % NREQ;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs against the model, advance the model,
    // then move to the next falling edge.
    task automatic cycle();
        int         g;
        logic [3:0] eg;
        #1;
        g  = exp_gidx();
        eg = (g < 0) ? 4'b0000 : 4'(1 << g);
        check("gnt", gnt, eg);
        check("out_valid", out_valid, (mq.size() != 0));
        check("count", count, mq.size());
        if (mq.size() != 0) begin
            check("out_data", out_data, mq[0][7:0]);
            check("out_src", out_src, mq[0][9:8]);
        end
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (g >= 0) begin
            mq.push_back({2'(g), wdata[g*8 +: 8]});
            m_pp = (g + 1) % NREQ;
        end
        last_g = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        req       = 4'b0000;
        out_ready = 1'b1;
        for (int n = 0; n < 2 * DEPTH; n++) begin
            if (mq.size() == 0) break;
            cycle();
        end
        check("drain_empty", count, 3'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        mq.delete();
        m_pp = 0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_src", out_src, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] pend;
        rst       = 1'b1;
        req       = 4'b1111;
        wdata     = 32'h0;
        out_ready = 1'b0;
        @(negedge clk);
        apply_reset();

        // Round robin with all requesters active and a consumer always ready.
        req       = 4'b1111;
        wdata     = 32'h13121110;
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) cycle();
        drain();

        // Fill to three, then reset mid-run.
        out_ready = 1'b0;
        req       = 4'b0001;
        for (int n = 0; n < 3; n++) cycle();
        check("pre_rst_count", count, 3'd3);
        req = 4'b0001;
        apply_reset();
        req = 4'b0100;
        #1;
        check("post_rst_gnt", gnt, 4'b0100);
        cycle();
        drain();

        // Fill and stall.
        out_ready = 1'b0;
        req       = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            wdata = {24'h0, 8'hA0 + 8'(n)};
            cycle();
        end
        check("full_count", count, 3'd4);
        out_ready = 1'b1;
        cycle();
        check("after_read_count", count, 3'd3);
        out_ready = 1'b0;
        cycle();

        // Simultaneous read and request at full.
        req       = 4'b0010;
        wdata     = 32'h00005500;
        out_ready = 1'b1;
        check("sim_full_count", count, 3'd4);
        cycle();
        cycle();
        check("sim_steady_count", count, 3'd3);
        drain();

        // Pointer wrap with alternating consumer.
        req = 4'b0001;
        for (int n = 0; n < 9; n++) begin
            wdata     = 32'(n + 1);
            out_ready = (n % 2 == 0);
            cycle();
        end
        drain();

        // Skip idle requesters: grant to 2 leaves priority at 3.
        out_ready = 1'b1;
        req       = 4'b0100;
        cycle();
        req = 4'b0101;
        #1;
        check("skip_wrap_gnt", gnt, 4'b0001);
        cycle();
        #1;
        check("skip_next_gnt", gnt, 4'b0100);
        cycle();
        drain();

        // Random traffic; requests stay up until granted.
        pend = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            pend      = pend | 4'($urandom_range(0, 15));
            req       = pend;
            wdata     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (last_g >= 0) pend[last_g] = ($urandom_range(0, 1) == 1);
            if (n == 200) apply_reset();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_buf_sched.md
# rr_buf_sched

Round-robin scheduler that shares one small byte buffer between NREQ producers and drains it to a single consumer over a valid/ready handshake. It replaces ad-hoc write/read strobing of the shared buffer register with fair arbitration, occupancy tracking and source tagging. It sits between the producer blocks and the downstream byte consumer.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width in bits
- DEPTH, 4, buffer entries; power of 2, at least 2
- clk  input  1  clock, rising-edge active
- rst  input  1  reset, asynchronous, active-low
- req  input  NREQ  per-requester write request; bit i belongs to requester i
- wdata  input  NREQ*DW  requester i data in bits [i*DW +: DW]
- gnt  output  NREQ  one-hot grant, combinational; the granted word is written at the next rising edge
- out_valid  output  1  buffer holds at least one word
- out_ready  input  1  consumer accepts the head word this cycle
- out_data  output  DW  head word; registered storage, no combinational path from wdata
- out_src  output  $clog2(NREQ)  index of the requester that wrote the head word
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH x (DW + src) entries, write pointer wp, read pointer rp, both log2(DEPTH) bits; they wrap naturally from DEPTH-1 to 0.
- Priority pointer pp, range 0..NREQ-1. Search order is pp, pp+1, ..., NREQ-1, 0, ..., pp-1; the first requester with req=1 is granted.
- gnt is all-zero when count==DEPTH, when req==0, or while rst is low. No write bypass when full, even if a read happens in the same cycle.
- Write (gnt!=0) at the rising edge:
  - mem[wp] <= wdata of the granted requester, tagged with its index.
  - wp advances by 1.
  - pp <= granted index + 1, modulo NREQ.
- pp is unchanged on cycles with no grant.
- Read (out_valid && out_ready) at the rising edge: rp advances by 1. out_ready is ignored when count==0.
- count is +1 on a write only, -1 on a read only, and unchanged on both or neither.
- out_valid = (count != 0). out_data and out_src = mem[rp].
- Requester protocol:
  - Hold req and wdata stable until gnt is seen.
  - A requester that sees gnt may drop req or present new data next cycle.
  - Keeping req high requests another write.
- Reset (rst low, asynchronous): count=0, wp=rp=0, pp=0, all storage cleared.
  - Outputs during reset: out_valid=0, out_data=0, out_src=0, count=0, gnt=0.
  - Reset mid-operation discards buffered data with no drain.
  - Release is synchronous to the first rising edge with rst high.

## Timing
- Write to visible: a word granted in cycle N appears on out_data with out_valid=1 in cycle N+1 if the buffer was empty.
- Read: head removed at the edge closing a cycle with out_valid && out_ready; the next entry is visible the following cycle.
- Back-to-back: one write and one read per cycle sustained; count stays constant.
- Full: count==DEPTH gives gnt=0 the same cycle. A read frees a slot, so gnt may assert from the next cycle.
- Empty: a write with no read gives count=1 next cycle. A read presented while empty has no effect.
- Fairness: with all NREQ requesting continuously, each requester gets exactly one grant in every NREQ consecutive grants.

## Test plan
- Reset values: assert rst mid-run with count=3 → out_valid=0, count=0, gnt=0, out_data=0 immediately. After release, req=4'b0100 → gnt=4'b0100 (pp=0, search reaches index 2).
- Round robin: req=4'b1111 held, out_ready=1, wdata i = 8'h10+i → gnt sequence 0001, 0010, 0100, 1000, 0001. out_data/out_src sequence 10/0, 11/1, 12/2, 13/3, each one cycle after its grant.
- Fill and stall: out_ready=0, req=4'b0001, wdata 8'hA0..A3 → count reaches 4 after 4 grants; gnt=0 in the 5th cycle. Then out_ready=1 for one cycle → out_data=A0 consumed, count=3, gnt=0001 the next cycle.
- Simultaneous at full: count=4, req=4'b0010, out_ready=1 → no grant that cycle (gnt=0), count=3 next. Next cycle gnt=0010, read+write, count stays 3.
- Pointer wrap: DEPTH=4, push and pop 9 words 8'h01..8'h09 with out_ready toggling 1,0 → outputs 01..09 in order, no loss or duplication, final count=0.
- Skip idle requesters: pp=3 after a grant to 2, req=4'b0101 → gnt=0001 (wraps past 3), then pp=1 → gnt=0100.
